// File: rtl/ncl_sink_sync.sv
// Clocked sink for the NCL adder ring: synchronizes the dual-rail bus, decodes stable
// DATA wavefronts onto a valid/ready port and returns the NCL acknowledge upstream.
module ncl_sink_sync #(
   parameter int WIDTH  = 4,
   parameter int STABLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2*WIDTH-1:0]   bus_in,
   output logic                 ack_out,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [CNT_W-1:0]     token_count,
   output logic                 err
);

   localparam int STAB_W = $clog2(STABLE + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE);

   typedef enum logic [1:0] {WAIT_DATA, HOLD, WAIT_NULL} state_t;
   typedef enum logic [1:0] {CLS_NULL, CLS_DATA, CLS_ILLEGAL, CLS_INCOMPLETE} class_t;

   state_t              state, state_next;
   class_t              s2_class;
   logic [2*WIDTH-1:0]  s1, s2;
   logic [STAB_W-1:0]   stab_cnt;
   logic [WIDTH-1:0]    s2_value;
   logic                any_illegal, all_pairs_valid;
   logic                qualified, buf_free;
   logic                capture, count_inc, err_set;

   // The counter compares the value about to enter s2 with s2 itself, so after any
   // edge it holds how many cycles the current s2 value has been present.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1       <= '0;
         s2       <= '0;
         stab_cnt <= '0;
      end else begin
         s1 <= bus_in;
         s2 <= s1;
         if (s1 != s2)
            stab_cnt <= STAB_W'(1);
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + STAB_W'(1);
      end
   end

   always_comb begin
      s2_value        = '0;
      any_illegal     = 1'b0;
      all_pairs_valid = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         s2_value[i] = s2[2*i+1];
         if (s2[2*i+1] && s2[2*i])
            any_illegal = 1'b1;
         if (s2[2*i+1] == s2[2*i])
            all_pairs_valid = 1'b0;
      end
      if (any_illegal)
         s2_class = CLS_ILLEGAL;
      else if (s2 == '0)
         s2_class = CLS_NULL;
      else if (all_pairs_valid)
         s2_class = CLS_DATA;
      else
         s2_class = CLS_INCOMPLETE;
   end

   assign qualified = (stab_cnt == STAB_MAX);
   assign buf_free  = !dout_valid || dout_ready;

   always_ff @(posedge clk) begin
      if (reset)
         state <= WAIT_DATA;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      count_inc  = 1'b0;
      err_set    = qualified && (s2_class == CLS_ILLEGAL);
      case (state)
         WAIT_DATA: begin
            if (qualified && (s2_class == CLS_DATA)) begin
               if (buf_free) begin
                  capture    = 1'b1;
                  state_next = WAIT_NULL;
               end else begin
                  state_next = HOLD;
               end
            end
         end
         // Upstream broke protocol if the wavefront vanishes before we acknowledged it.
         HOLD: begin
            if (s2_class != CLS_DATA) begin
               err_set    = 1'b1;
               state_next = WAIT_DATA;
            end else if (qualified && buf_free) begin
               capture    = 1'b1;
               state_next = WAIT_NULL;
            end
         end
         WAIT_NULL: begin
            if (qualified && (s2_class == CLS_NULL)) begin
               count_inc  = 1'b1;
               state_next = WAIT_DATA;
            end
         end
         default: state_next = WAIT_DATA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_out     <= 1'b1;
         dout        <= '0;
         dout_valid  <= 1'b0;
         token_count <= '0;
         err         <= 1'b0;
      end else begin
         ack_out <= (state_next != WAIT_NULL);
         if (capture)
            dout <= s2_value;
         if (capture)
            dout_valid <= 1'b1;
         else if (dout_ready)
            dout_valid <= 1'b0;
         if (count_inc)
            token_count <= token_count + CNT_W'(1);
         if (err_set)
            err <= 1'b1;
      end
   end

endmodule

// File: doc/ncl_sink_sync.md
Name: ncl_sink_sync

Overview:
- Clocked consumer at the output of the asynchronous NCL adder ring.
- Takes the 2*WIDTH-bit dual-rail bus produced by the final latch stage and drives the NCL acknowledge back into that stage.
- Decodes each complete DATA wavefront into a single-rail value, delivers it over a valid/ready interface, and counts completed DATA/NULL cycles.
- Applies backpressure to the ring by withholding the acknowledge while its output register is full.

Parameters:
WIDTH, 4, number of logical bits; bus is 2*WIDTH rails
STABLE, 2, consecutive synchronized cycles a complete code must hold before acceptance (>=1)
CNT_W, 16, width of token counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bus_in  input  2*WIDTH  dual-rail data; bit i: rail1=bus_in[2i+1], rail0=bus_in[2i]
ack_out  output  1  NCL acknowledge to upstream latch: 1=request-for-data, 0=request-for-null
dout  output  WIDTH  decoded value; dout[i]=rail1 of pair i
dout_valid  output  1  dout holds an unconsumed token
dout_ready  input  1  consumer accepts dout
token_count  output  CNT_W  completed DATA->NULL cycles, wraps modulo 2^CNT_W
err  output  1  sticky protocol error flag

Behaviour:
- Reset is synchronous, active-high and dominates all other events. Reset values:
  - ack_out=1, dout=0, dout_valid=0, token_count=0, err=0
  - sync registers cleared, state=WAIT_DATA
- Reset mid-token discards the token. If bus_in still carries DATA after reset, it is accepted as a new token.
- Synchronizer: bus_in -> s1 -> s2 (two flops, all rails).
- Stability counter:
  - Increments (saturating at STABLE) while s2 equals its previous-cycle value.
  - Loads 1 when s2 changes.
  - s2 is "qualified" when the counter reaches STABLE.
- Classification of s2:
  - NULL: all rails 0.
  - DATA: every pair exactly 01 or 10.
  - ILLEGAL: any pair 11.
  - Anything else is INCOMPLETE.
- ILLEGAL, when qualified: sets err; is never accepted.
- Buffer "free" = !dout_valid, or dout_valid & dout_ready in the same cycle.
- States:
  - WAIT_DATA (ack_out=1):
    - qualified DATA and buffer free: capture dout, dout_valid<=1, ack_out<=0 -> WAIT_NULL.
    - qualified DATA and buffer full: -> HOLD.
  - HOLD (ack_out=1):
    - buffer free and s2 still qualified DATA: capture as above -> WAIT_NULL.
    - s2 leaves DATA: set err -> WAIT_DATA; nothing captured. Upstream must not withdraw DATA while ack_out=1.
  - WAIT_NULL (ack_out=0):
    - qualified NULL: ack_out<=1, token_count+1 -> WAIT_DATA.
    - DATA/INCOMPLETE patterns are ignored here.
- Latency: with bus_in settled before edge N, s2 shows it after edge N+1. Capture/ack change happens at edge N+STABLE+1 (edge N+3 for STABLE=2). NULL acceptance has the same latency.
- dout handshake:
  - dout is stable while dout_valid=1.
  - dout_valid clears at an edge with dout_ready=1, unless a new capture occurs at the same edge; then dout_valid stays 1 with the new value.
  - dout_ready while !dout_valid has no effect.
- token_count increments only on WAIT_NULL->WAIT_DATA. It wraps from 2^CNT_W-1 to 0.
- err clears only on reset.

Test Plan:
1. Reset, then bus_in=8'b00000000 -> ack_out=1, dout_valid=0, token_count=0, err=0.
2. bus_in=8'b10011001 (value 4'b1010) held, dout_ready=1 -> 3 edges later dout=4'hA, dout_valid=1, ack_out=0. Then bus_in=0 -> 3 edges later ack_out=1, token_count=1.
3. Two tokens 4'h5 then 4'h3 with dout_ready=0:
   - First token captured; second DATA moves to HOLD with ack_out=1.
   - Pulse dout_ready one cycle -> 4'h5 consumed, 4'h3 captured on the same edge, dout_valid stays 1.
4. Glitch: bus_in passes INCOMPLETE 8'b00000001 for 1 cycle, then 8'b01010101 -> no capture of partial code; dout=4'h0 captured; err=0.
5. bus_in pair 11 (8'b00000011) held 3 cycles -> err=1, no capture. err persists after a normal token until reset.
6. CNT_W=4, run 17 DATA/NULL cycles -> token_count=1. Assert reset while in WAIT_NULL -> all outputs return to reset values on the next edge.
